// File: rtl/gpu_arb_pkg.sv
// Shared types and constants for the GPU RAM arbiter.
package gpu_arb_pkg;

  localparam int unsigned NUM_PORTS  = 3;
  localparam int unsigned PORT_Z80   = 0;
  localparam int unsigned PORT_RS232 = 1;
  localparam int unsigned PORT_AUX   = 2;

  typedef logic [1:0] port_id_t;

  // Read tag carried through the return pipeline.
  typedef struct packed {
    logic     valid;
    port_id_t id;
  } tag_t;

  // Round-robin successor: 0 -> 1 -> 2 -> 0.
  function automatic port_id_t next_port(port_id_t p);
    return (p == port_id_t'(NUM_PORTS - 1)) ? port_id_t'(0) : p + port_id_t'(1);
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_onehot(port_id_t id);
    logic [NUM_PORTS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gpu_ram_arbiter_if.sv
// Host-side request bus plus GPU RAM port of the arbiter.
interface gpu_ram_arbiter_if
  import gpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 20
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*8-1:0]      wdata;
  logic [NUM_PORTS-1:0]        busy;
  logic [NUM_PORTS-1:0]        rd_rdy;
  logic [7:0]                  rd_data;
  logic [7:0]                  gpu_data_in;
  logic [ADDR_W-1:0]           gpu_address;
  logic [7:0]                  gpu_data_out;
  logic                        gpu_wr_ena;

  // Requesters and RAM model side.
  modport master (
    output req, we, addr, wdata, gpu_data_in,
    input  busy, rd_rdy, rd_data, gpu_address, gpu_data_out, gpu_wr_ena
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, gpu_data_in,
    output busy, rd_rdy, rd_data, gpu_address, gpu_data_out, gpu_wr_ena
  );
endinterface

// File: rtl/gpu_arb_rd_pipe.sv
// Read tag delay line: a tag pushed at the issue edge returns DELAY_CYCLES
// edges later, where the RAM byte is captured and the owner is pulsed.
module gpu_arb_rd_pipe
  import gpu_arb_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  tag_t                 push,
  input  logic [7:0]           gpu_data_in,
  output tag_t                 ret,
  output logic [NUM_PORTS-1:0] rd_rdy,
  output logic [7:0]           rd_data
);

  tag_t stage_q [DELAY_CYCLES];

  assign ret = stage_q[DELAY_CYCLES-1];

  // Shift tags and capture the returning byte for its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DELAY_CYCLES; i++) stage_q[i] <= '0;
      rd_rdy  <= '0;
      rd_data <= '0;
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < DELAY_CYCLES; i++) stage_q[i] <= stage_q[i-1];
      rd_rdy <= ret.valid ? port_onehot(ret.id) : '0;
      if (ret.valid) rd_data <= gpu_data_in;
    end
  end

endmodule

// File: rtl/gpu_ram_arbiter.sv
// Three-port arbiter for the single GPU RAM access port.
// Optional macro GPU_ARB_ROUND_ROBIN_EN selects round-robin grant instead of
// fixed priority 0 > 1 > 2.
module gpu_ram_arbiter
  import gpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DELAY_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  gpu_ram_arbiter_if.slave bus
);

  logic [NUM_PORTS-1:0] pend_q, pend_d, busy_q, busy_d, we_q, accept;
  logic [ADDR_W-1:0]    addr_q  [NUM_PORTS];
  logic [7:0]           wdata_q [NUM_PORTS];
  logic [ADDR_W-1:0]    gpu_address_q;
  logic [7:0]           gpu_data_out_q;
  logic                 gpu_wr_ena_q;
  logic                 gnt_valid;
  port_id_t             gnt_id;
  tag_t                 push, ret;

  assign accept = bus.req & ~busy_q;

`ifdef GPU_ARB_ROUND_ROBIN_EN
  port_id_t ptr_q;

  // Search pending slots starting after the last granted port.
  always_comb begin
    port_id_t cand;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = next_port(ptr_q);
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_valid && pend_q[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
      cand = next_port(cand);
    end
  end

  // Last-grant pointer moves only when something is granted.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= port_id_t'(NUM_PORTS - 1);
    else if (gnt_valid) ptr_q <= gnt_id;
  end
`else
  // Fixed priority: lowest pending port index wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        gnt_valid = 1'b1;
        gnt_id    = port_id_t'(k);
      end
    end
  end
`endif

  // Pending/busy next state: grant and return clear, acceptance sets.
  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    if (gnt_valid) begin
      pend_d[gnt_id] = 1'b0;
      if (we_q[gnt_id]) busy_d[gnt_id] = 1'b0;
    end
    if (ret.valid) busy_d[ret.id] = 1'b0;
    pend_d = pend_d | accept;
    busy_d = busy_d | accept;
  end

  // Only reads are tracked through the return pipeline.
  always_comb begin
    push       = '0;
    push.valid = gnt_valid && !we_q[gnt_id];
    push.id    = gnt_id;
  end

  // Slot registers; a busy slot never re-captures, so a granted slot is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      busy_q <= '0;
      we_q   <= '0;
      for (int n = 0; n < NUM_PORTS; n++) begin
        addr_q[n]  <= '0;
        wdata_q[n] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (accept[n]) begin
          we_q[n]    <= bus.we[n];
          addr_q[n]  <= bus.addr[n*ADDR_W +: ADDR_W];
          wdata_q[n] <= bus.wdata[n*8 +: 8];
        end
      end
    end
  end

  // RAM port registers; address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_address_q  <= '0;
      gpu_data_out_q <= '0;
      gpu_wr_ena_q   <= 1'b0;
    end else begin
      gpu_wr_ena_q <= gnt_valid && we_q[gnt_id];
      if (gnt_valid) begin
        gpu_address_q  <= addr_q[gnt_id];
        gpu_data_out_q <= wdata_q[gnt_id];
      end
    end
  end

  gpu_arb_rd_pipe #(
    .DELAY_CYCLES (DELAY_CYCLES)
  ) u_rd_pipe (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .gpu_data_in (bus.gpu_data_in),
    .ret         (ret),
    .rd_rdy      (bus.rd_rdy),
    .rd_data     (bus.rd_data)
  );

  assign bus.busy         = busy_q;
  assign bus.gpu_address  = gpu_address_q;
  assign bus.gpu_data_out = gpu_data_out_q;
  assign bus.gpu_wr_ena   = gpu_wr_ena_q;

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// Directed bench for gpu_ram_arbiter (DELAY_CYCLES = 2).
module tb_gpu_ram_arbiter;

  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] ram_q = '0;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic          rst;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] a0, a1, a2;
    logic [23:0]   wdata;
    logic [2:0]    busy;
    logic [2:0]    rdy;
    logic [7:0]    rdata;
    logic [AW-1:0] gaddr;
    logic [7:0]    dout;
    logic          wr;
  } vec_t;

  vec_t vq[$];

  gpu_ram_arbiter_if #(.ADDR_W(AW)) bus ();

  gpu_ram_arbiter #(
    .ADDR_W       (AW),
    .DELAY_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: byte appears two edges after the address is issued.
  function automatic logic [7:0] ram_byte(logic [AW-1:0] a);
    return (a == 20'h01234) ? 8'hA5 : a[7:0];
  endfunction

  always @(posedge clk) ram_q <= bus.gpu_address;
  assign bus.gpu_data_in = ram_byte(ram_q);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic rst, logic [2:0] req, logic [2:0] we, logic [AW-1:0] a0,
                     logic [AW-1:0] a1, logic [23:0] wdata, logic [2:0] busy,
                     logic [2:0] rdy, logic [7:0] rdata, logic [AW-1:0] gaddr,
                     logic [7:0] dout, logic wr);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
    v.a2 = a0 + 20'h2; v.wdata = wdata; v.busy = busy; v.rdy = rdy;
    v.rdata = rdata; v.gaddr = gaddr; v.dout = dout; v.wr = wr;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".rd_rdy"}, 32'(bus.rd_rdy), 0);
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, ".gpu_address"}, 32'(bus.gpu_address), 0);
    chk({tag, ".gpu_data_out"}, 32'(bus.gpu_data_out), 0);
    chk({tag, ".gpu_wr_ena"}, 32'(bus.gpu_wr_ena), 0);
  endtask

  initial begin
    int completions, bad, stray, grants;
    logic [7:0] last_data;
    logic seen2, first0;

    // Per-cycle script: inputs for the cycle, outputs expected after its edge.
    //   rst  req     we      a0(a2=a0+2) a1         wdata       busy    rdy     rdata  gaddr       dout  wr
    add(0, 3'b111, 3'b111, 20'h00100, 20'h00101, 24'h332211, 3'b111, 3'b000, 8'h00, 20'h00000, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b110, 3'b000, 8'h00, 20'h00100, 8'h11, 1);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b100, 3'b000, 8'h00, 20'h00101, 8'h22, 1);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'h00, 20'h00102, 8'h33, 1);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'h00, 20'h00102, 8'h33, 0);
    add(0, 3'b111, 3'b111, 20'h00200, 20'h00201, 24'h665544, 3'b111, 3'b000, 8'h00, 20'h00102, 8'h33, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b110, 3'b000, 8'h00, 20'h00200, 8'h44, 1);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b100, 3'b000, 8'h00, 20'h00201, 8'h55, 1);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'h00, 20'h00202, 8'h66, 1);
    add(0, 3'b001, 3'b000, 20'h01234, 20'h00000, 24'h000000, 3'b001, 3'b000, 8'h00, 20'h00202, 8'h66, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b001, 3'b000, 8'h00, 20'h01234, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b001, 3'b000, 8'h00, 20'h01234, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b001, 8'hA5, 20'h01234, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'hA5, 20'h01234, 8'h00, 0);
    add(1, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'h00, 20'h00000, 8'h00, 0);
    add(0, 3'b011, 3'b000, 20'h00010, 20'h00020, 24'h000000, 3'b011, 3'b000, 8'h00, 20'h00000, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b011, 3'b000, 8'h00, 20'h00010, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b011, 3'b000, 8'h00, 20'h00020, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b010, 3'b001, 8'h10, 20'h00020, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b010, 8'h20, 20'h00020, 8'h00, 0);
    add(0, 3'b000, 3'b000, 20'h00000, 20'h00000, 24'h000000, 3'b000, 3'b000, 8'h20, 20'h00020, 8'h00, 0);

    // Reset state.
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;

    foreach (vq[i]) begin
      reset     = vq[i].rst;
      bus.req   = vq[i].req;
      bus.we    = vq[i].we;
      bus.addr  = {vq[i].a2, vq[i].a1, vq[i].a0};
      bus.wdata = vq[i].wdata;
      tick();
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vq[i].busy));
      chk($sformatf("vec%0d.rd_rdy", i), 32'(bus.rd_rdy), 32'(vq[i].rdy));
      chk($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vq[i].rdata));
      chk($sformatf("vec%0d.gpu_address", i), 32'(bus.gpu_address), 32'(vq[i].gaddr));
      chk($sformatf("vec%0d.gpu_data_out", i), 32'(bus.gpu_data_out), 32'(vq[i].dout));
      chk($sformatf("vec%0d.gpu_wr_ena", i), 32'(bus.gpu_wr_ena), 32'(vq[i].wr));
    end
    reset = 1'b0;
    drive_idle();

    // Port 1 keeps requesting while busy, including the completion edge.
    completions = 0; bad = 0; last_data = '0;
    bus.req = 3'b010; bus.addr = {20'h0, 20'h00345, 20'h0};
    tick();
    bus.addr = {20'h0, 20'h00400, 20'h0};
    for (int c = 0; c < 11; c++) begin
      if (c == 3) bus.req = '0;
      if (bus.rd_rdy[1]) begin completions++; last_data = bus.rd_data; end
      if (bus.gpu_address == 20'h00400) bad++;
      tick();
    end
    chk("ignored.completions", 32'(completions), 1);
    chk("ignored.second_access", 32'(bad), 0);
    chk("ignored.rd_data", 32'(last_data), 32'h45);
    chk("ignored.busy", 32'(bus.busy), 0);
    drive_idle();

    // Reset one clock after a read issues drops its tag.
    bus.req = 3'b100; bus.addr = {20'h00456, 40'h0};
    tick();
    drive_idle();
    tick();
    chk("rstrd.issue_addr", 32'(bus.gpu_address), 32'h00456);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rstrd");
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.rd_rdy != 3'b000) stray++;
    end
    chk("rstrd.stray_rdy", 32'(stray), 0);
    bus.req = 3'b100; bus.addr = {20'h00478, 40'h0};
    tick();
    drive_idle();
    for (int c = 0; c < 8 && bus.rd_rdy == 3'b000; c++) tick();
    chk("rstrd.new_rdy", 32'(bus.rd_rdy), 32'b100);
    chk("rstrd.new_data", 32'(bus.rd_data), 32'h78);
    chk("rstrd.new_busy", 32'(bus.busy), 0);
    tick();

    // Port 0 re-requests writes as soon as it frees up; port 2 must still get in.
    grants = 0; seen2 = 1'b0; first0 = 1'b0;
    bus.req = 3'b101; bus.we = 3'b101;
    bus.addr = {20'h00502, 20'h0, 20'h00500}; bus.wdata = 24'hCC00AA;
    tick();
    for (int c = 0; c < 10 && !seen2; c++) begin
      bus.req = {2'b00, ~bus.busy[0]};
      tick();
      if (bus.gpu_wr_ena) begin
        grants++;
        if (grants == 1 && bus.gpu_address == 20'h00500) first0 = 1'b1;
        if (bus.gpu_address == 20'h00502) seen2 = 1'b1;
      end
    end
    chk("starve.first_port0", 32'(first0), 1);
    chk("starve.port2_granted", 32'(seen2), 1);
    chk("starve.within3", 32'(grants <= 3), 1);
    drive_idle();
    for (int c = 0; c < 6; c++) tick();
    chk("starve.drained", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
